// File: rtl/fir_cfg_pkg.sv
// Shared FIR configuration constants: loader state encoding, error codes, sizing helpers.
package fir_cfg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_TMO   = 2'd1;
  localparam logic [1:0] ERR_SUM   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  // Number of stored coefficients for a symmetric filter of the given order
  function automatic int unsigned calc_nc(input int unsigned ord);
    return (ord + 1) >> 1;
  endfunction

  // Coefficient address width; at least one bit so the port never collapses
  function automatic int unsigned calc_aw(input int unsigned ord);
    return (calc_nc(ord) > 1) ? $clog2(calc_nc(ord)) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams a full coefficient set into the fir coefficient-write port,
// checks a modular checksum and reports done or a sticky error.
module fir_coeff_loader
  import fir_cfg_pkg::*;
#(
  parameter int unsigned ORD = 256,
  parameter int unsigned C   = 16,
  parameter int unsigned TMO = 1024,
  localparam int unsigned AW = calc_aw(ORD)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic [C-1:0]  exp_sum,
  input  logic          s_valid,
  input  logic [C-1:0]  s_data,
  output logic          s_ready,
  output logic          c_WE,
  output logic [C-1:0]  c_in,
  output logic [AW-1:0] c_addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int unsigned NC = calc_nc(ORD);
  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [1:0]    r_state,    w_state_nxt;
  logic [AW-1:0] r_cnt,      w_cnt_nxt;
  logic [C-1:0]  r_sum,      w_sum_nxt;
  logic [C-1:0]  r_exp,      w_exp_nxt;
  logic [TW-1:0] r_timer,    w_timer_nxt;
  logic          r_we,       w_we_nxt;
  logic [C-1:0]  r_cin,      w_cin_nxt;
  logic [AW-1:0] r_caddr,    w_caddr_nxt;
  logic          r_done,     w_done_nxt;
  logic          r_err,      w_err_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          w_hs;

  // Ready only while loading; an abort in the same cycle blocks the word
  assign s_ready = (r_state == ST_LOAD) && !abort;
  assign w_hs    = s_valid && s_ready;

  assign c_WE     = r_we;
  assign c_in     = r_cin;
  assign c_addr   = r_caddr;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sum_nxt      = r_sum;
    w_exp_nxt      = r_exp;
    w_timer_nxt    = r_timer;
    w_we_nxt       = 1'b0;
    w_cin_nxt      = r_cin;
    w_caddr_nxt    = r_caddr;
    w_done_nxt     = 1'b0;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;

    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt    = ST_LOAD;
          w_exp_nxt      = exp_sum;
          w_cnt_nxt      = '0;
          w_sum_nxt      = '0;
          w_timer_nxt    = '0;
          w_err_nxt      = 1'b0;
          w_err_code_nxt = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt    = ST_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_ABORT;
        end else if (w_hs) begin
          w_we_nxt    = 1'b1;
          w_cin_nxt   = s_data;
          w_caddr_nxt = r_cnt;
          w_sum_nxt   = r_sum + s_data;
          w_cnt_nxt   = r_cnt + AW'(1);
          w_timer_nxt = '0;
          if (r_cnt == AW'(NC - 1)) begin
            w_state_nxt = ST_CHECK;
          end
        end else if (r_timer == TW'(TMO - 1)) begin
          w_state_nxt    = ST_IDLE;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TMO;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (r_sum == r_exp) begin
          w_done_nxt = 1'b1;
        end else begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_SUM;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_exp      <= '0;
      r_timer    <= '0;
      r_we       <= 1'b0;
      r_cin      <= '0;
      r_caddr    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sum      <= w_sum_nxt;
      r_exp      <= w_exp_nxt;
      r_timer    <= w_timer_nxt;
      r_we       <= w_we_nxt;
      r_cin      <= w_cin_nxt;
      r_caddr    <= w_caddr_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized bench for fir_coeff_loader against a behavioural load model.
module tb_fir_coeff_loader;

  localparam int unsigned ORD = 256;
  localparam int unsigned C   = 16;
  localparam int unsigned TMO = 16;
  localparam int unsigned NC  = 128;
  localparam int unsigned AW  = 7;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_CHECK = 2;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic          abort;
  logic [C-1:0]  exp_sum;
  logic          s_valid;
  logic [C-1:0]  s_data;
  logic          s_ready;
  logic          c_WE;
  logic [C-1:0]  c_in;
  logic [AW-1:0] c_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;

  fir_coeff_loader #(.ORD(ORD), .C(C), .TMO(TMO)) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .exp_sum(exp_sum),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .c_WE(c_WE),
    .c_in(c_in), .c_addr(c_addr), .busy(busy), .done(done), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Single comparison point: count and report
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Write-port monitor, sampled on the falling edge
  int unsigned  wr_a[$];
  logic [C-1:0] wr_d[$];
  always @(negedge clk) begin
    if (nrst === 1'b1 && c_WE === 1'b1) begin
      wr_a.push_back(32'(c_addr));
      wr_d.push_back(c_in);
    end
  end

  // Reference model: phase, accepted words, expected flags
  int           m_phase = P_IDLE;
  logic [C-1:0] m_words[$];
  logic [C-1:0] m_exp = '0;
  int           m_idle = 0;
  logic         m_err = 1'b0;
  logic [1:0]   m_code = 2'd0;
  logic         m_done_pend = 1'b0;
  int           step_no = 0;
  int           m_start_step = 0;
  int           m_done_lat = 0;
  logic [C-1:0] src[$];

  task automatic check_writes();
    chk("wr_count", 32'(wr_a.size()), 32'(m_words.size()));
    foreach (m_words[i]) begin
      if (i < wr_a.size()) begin
        chk("wr_addr", wr_a[i], 32'(i));
        chk("wr_data", 32'(wr_d[i]), 32'(m_words[i]));
      end
    end
    wr_a.delete();
    wr_d.delete();
    m_words.delete();
  endtask

  task automatic check_reset_vals();
    chk("rst_c_WE", 32'(c_WE), 32'(0));
    chk("rst_c_in", 32'(c_in), 32'(0));
    chk("rst_c_addr", 32'(c_addr), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_s_ready", 32'(s_ready), 32'(0));
  endtask

  // One clock cycle: check post-edge state, apply inputs, advance the model
  task automatic step(input logic v, input logic [C-1:0] d, input logic ab,
                      input logic st, input logic [C-1:0] es, output logic hs);
    int unsigned sum;
    @(posedge clk);
    #2;
    step_no++;
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
    chk("done", 32'(done), 32'(m_done_pend));
    if (done === 1'b1) m_done_lat = step_no - m_start_step - 1;
    m_done_pend = 1'b0;
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    s_valid = v; s_data = d; abort = ab; start = st; exp_sum = es;
    #1;
    chk("s_ready", 32'(s_ready), 32'((m_phase == P_LOAD) && !ab));
    hs = 1'b0;
    case (m_phase)
      P_IDLE: begin
        if (st && !ab) begin
          check_writes();
          m_phase = P_LOAD; m_exp = es; m_err = 1'b0; m_code = 2'd0;
          m_idle = 0; m_start_step = step_no;
        end
      end
      P_LOAD: begin
        if (ab) begin
          m_phase = P_IDLE; m_err = 1'b1; m_code = 2'd3;
        end else if (v) begin
          hs = 1'b1;
          m_words.push_back(d);
          m_idle = 0;
          if (m_words.size() == NC) m_phase = P_CHECK;
        end else begin
          m_idle++;
          if (m_idle >= int'(TMO)) begin
            m_phase = P_IDLE; m_err = 1'b1; m_code = 2'd1;
          end
        end
      end
      default: begin
        sum = 0;
        foreach (m_words[k]) sum += 32'(m_words[k]);
        if (C'(sum) == m_exp) m_done_pend = 1'b1;
        else begin m_err = 1'b1; m_code = 2'd2; end
        m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    s_valid = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_reset_vals();
    check_writes();
    m_phase = P_IDLE; m_err = 1'b0; m_code = 2'd0; m_done_pend = 1'b0; m_idle = 0;
    @(negedge clk);
    #1;
    nrst = 1'b1;
  endtask

  task automatic fill_src(input bit rnd);
    src.delete();
    for (int i = 0; i < int'(NC); i++) src.push_back(rnd ? C'($urandom) : C'(i));
  endtask

  function automatic logic [C-1:0] src_sum();
    int unsigned s = 0;
    foreach (src[i]) s += 32'(src[i]);
    return C'(s);
  endfunction

  // Drive one load from src; negative markers disable abort/stop/reset
  task automatic run_load(input logic [C-1:0] esum, input int gap_max,
                          input int abort_at, input int stop_at, input int reset_at);
    int   i = 0;
    int   run = 0;
    int   guard = 0;
    logic hs;
    step(1'b0, C'(0), 1'b0, 1'b1, esum, hs);
    while (m_phase != P_IDLE) begin
      guard++;
      if (guard > 4000) begin
        chk("load_guard", 32'(guard), 32'(4000));
        break;
      end
      if (i == reset_at) begin
        do_reset();
        break;
      end
      if (i >= int'(NC) || i == stop_at) begin
        step(1'b0, C'($urandom), 1'b0, 1'b0, C'(0), hs);
      end else if (i == abort_at) begin
        step(1'b1, src[i], 1'b1, 1'b0, C'(0), hs);
      end else if (gap_max > 0 && run < gap_max && $urandom_range(0, 2) == 0) begin
        step(1'b0, C'($urandom), 1'b0, 1'b0, C'(0), hs);
        run++;
      end else begin
        step(1'b1, src[i], 1'b0, 1'b0, C'(0), hs);
        run = 0;
        if (hs) i++;
      end
    end
  endtask

  initial begin
    logic hs;
    nrst = 1'b0; start = 1'b0; abort = 1'b0; exp_sum = '0; s_valid = 1'b0; s_data = '0;
    #1;
    check_reset_vals();
    #20;
    nrst = 1'b1;

    // Nominal 0..127 load, then a back-to-back load with a wrong checksum
    fill_src(1'b0);
    run_load(16'h1FC0, 0, -1, -1, -1);
    run_load(16'h1FC1, 0, -1, -1, -1);
    chk("done_latency", 32'(m_done_lat), 32'(NC + 1));

    // Timeout after five words, then a randomly stalled load with a good checksum
    fill_src(1'b1);
    run_load(src_sum(), 0, -1, 5, -1);
    fill_src(1'b1);
    m_done_lat = 0;
    run_load(src_sum(), 10, -1, -1, -1);
    step(1'b0, C'(0), 1'b0, 1'b0, C'(0), hs);
    chk("stall_done_seen", 32'(m_done_lat > int'(NC)), 32'(1));

    // Abort together with a valid word 40, then start+abort collision in idle
    fill_src(1'b1);
    run_load(src_sum(), 0, 40, -1, -1);
    step(1'b0, C'(0), 1'b1, 1'b1, C'(16'h1234), hs);
    step(1'b0, C'(0), 1'b0, 1'b0, C'(0), hs);

    // Reset at word 60, then a fresh load to completion
    fill_src(1'b1);
    run_load(src_sum(), 3, -1, -1, 60);
    fill_src(1'b1);
    run_load(src_sum(), 0, -1, -1, -1);
    for (int k = 0; k < 4; k++) step(1'b0, C'(0), 1'b0, 1'b0, C'(0), hs);
    check_writes();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
